// File: rtl/score_counter.sv
// score_counter: two-digit BCD score, edge-triggered increment, saturating at 99.
// Define SCORE_HIGH_SCORE_EN to add a high-score register pair on hs_ones/hs_tens.
module score_counter #(
   parameter int BLANK_LZ = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clear,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       en_ones,
   output logic       en_tens,
   output logic       full,
   output logic [3:0] hs_ones,
   output logic [3:0] hs_tens
);
   localparam logic COUNT = 1'b0;
   localparam logic SAT   = 1'b1;
   logic       inc_q, step;
   logic       state_q, state_d;
   logic [3:0] ones_q, ones_d, tens_q, tens_d;
   assign step = inc & ~inc_q;
   always_comb begin
      ones_d  = ones_q;
      tens_d  = tens_q;
      state_d = state_q;
      if (clear) begin
         ones_d  = 4'd0;
         tens_d  = 4'd0;
         state_d = COUNT;
      end else if (step && state_q == COUNT) begin
         // reaching 99 from 98, or stepping at 99, both land in SAT
         if (tens_q == 4'd9 && ones_q >= 4'd8) begin
            ones_d  = 4'd9;
            state_d = SAT;
         end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         inc_q   <= 1'b0;
         state_q <= COUNT;
         ones_q  <= 4'd0;
         tens_q  <= 4'd0;
      end else begin
         inc_q   <= inc;
         state_q <= state_d;
         ones_q  <= ones_d;
         tens_q  <= tens_d;
      end
   end
   assign ones    = ones_q;
   assign tens    = tens_q;
   assign full    = state_q == SAT;
   assign en_ones = 1'b1;
   assign en_tens = (BLANK_LZ != 0) ? (tens_q != 4'd0) : 1'b1;
`ifdef SCORE_HIGH_SCORE_EN
   logic [3:0] hs_ones_q, hs_tens_q;
   // packed BCD digits compare correctly as plain binary
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_ones_q <= 4'd0;
         hs_tens_q <= 4'd0;
      end else if ({tens_q, ones_q} > {hs_tens_q, hs_ones_q}) begin
         hs_ones_q <= ones_q;
         hs_tens_q <= tens_q;
      end
   end
   assign hs_ones = hs_ones_q;
   assign hs_tens = hs_tens_q;
`else
   assign hs_ones = 4'd0;
   assign hs_tens = 4'd0;
`endif
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed bench for score_counter, BLANK_LZ=1 and BLANK_LZ=0 instances side by side.
module tb_score_counter;
   logic       clk = 1'b0;
   logic       rst, inc, clear;
   logic [3:0] ones, tens, hs_ones, hs_tens, ones0, tens0, hs_ones0, hs_tens0;
   logic       en_ones, en_tens, full, en_ones0, en_tens0, full0;
   int         errs = 0;
   int         checks = 0;
   always #5 clk = ~clk;
   score_counter #(.BLANK_LZ(1)) u_dut (
      .clk(clk), .rst(rst), .inc(inc), .clear(clear),
      .ones(ones), .tens(tens), .en_ones(en_ones), .en_tens(en_tens),
      .full(full), .hs_ones(hs_ones), .hs_tens(hs_tens)
   );
   score_counter #(.BLANK_LZ(0)) u_dut0 (
      .clk(clk), .rst(rst), .inc(inc), .clear(clear),
      .ones(ones0), .tens(tens0), .en_ones(en_ones0), .en_tens(en_tens0),
      .full(full0), .hs_ones(hs_ones0), .hs_tens(hs_tens0)
   );
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) begin
         inc = 1'b1;
         @(negedge clk);
         inc = 1'b0;
         @(negedge clk);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      rst = 1'b1; inc = 1'b0; clear = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_score", {tens, ones}, 8'h00);
      chk("reset_full", {7'd0, full}, 8'h00);
      chk("reset_en_tens", {7'd0, en_tens}, 8'h00);
      chk("reset_en_ones", {7'd0, en_ones}, 8'h01);
      chk("reset_en_tens_lz0", {7'd0, en_tens0}, 8'h01);
      chk("reset_hs", {hs_tens, hs_ones}, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      pulse(12);
      chk("twelve_score", {tens, ones}, 8'h12);
      chk("twelve_en_tens", {7'd0, en_tens}, 8'h01);
      chk("twelve_full", {7'd0, full}, 8'h00);
      do_reset();
      inc = 1'b1;
      repeat (20) @(negedge clk);
      inc = 1'b0;
      @(negedge clk);
      chk("held_score", {tens, ones}, 8'h01);
      chk("held_en_tens", {7'd0, en_tens}, 8'h00);
      chk("held_en_tens_lz0", {7'd0, en_tens0}, 8'h01);
      do_reset();
      pulse(98);
      chk("at98_score", {tens, ones}, 8'h98);
      chk("at98_full", {7'd0, full}, 8'h00);
      inc = 1'b1;
      @(negedge clk);
      chk("at99_score", {tens, ones}, 8'h99);
      chk("at99_full", {7'd0, full}, 8'h01);
      inc = 1'b0;
      @(negedge clk);
      pulse(5);
      chk("sat_score", {tens, ones}, 8'h99);
      chk("sat_full", {7'd0, full}, 8'h01);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_score", {tens, ones}, 8'h00);
      chk("clear_full", {7'd0, full}, 8'h00);
      do_reset();
      pulse(9);
      chk("at09_score", {tens, ones}, 8'h09);
      inc = 1'b1; clear = 1'b1;
      @(negedge clk);
      chk("clr_inc_score", {tens, ones}, 8'h00);
      inc = 1'b0; clear = 1'b0;
      @(negedge clk);
      pulse(1);
      chk("after_clr_score", {tens, ones}, 8'h01);
`ifdef SCORE_HIGH_SCORE_EN
      do_reset();
      pulse(37);
      chk("hs_at37", {hs_tens, hs_ones}, 8'h37);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      pulse(15);
      chk("hs_score15", {tens, ones}, 8'h15);
      chk("hs_keep37", {hs_tens, hs_ones}, 8'h37);
      pulse(22);
      chk("hs_score37", {tens, ones}, 8'h37);
      inc = 1'b1;
      @(negedge clk);
      chk("hs_score38", {tens, ones}, 8'h38);
      chk("hs_lag37", {hs_tens, hs_ones}, 8'h37);
      inc = 1'b0;
      @(negedge clk);
      chk("hs_now38", {hs_tens, hs_ones}, 8'h38);
      do_reset();
      chk("hs_rst", {hs_tens, hs_ones}, 8'h00);
`else
      chk("hs_const0", {hs_tens, hs_ones}, 8'h00);
      chk("hs_const0_lz0", {hs_tens0, hs_ones0}, 8'h00);
`endif
      do_reset();
      pulse(56);
      chk("at56_score", {tens, ones}, 8'h56);
      rst = 1'b1; inc = 1'b1;
      @(negedge clk);
      rst = 1'b0; inc = 1'b0;
      chk("midrst_score", {tens, ones}, 8'h00);
      chk("midrst_full", {7'd0, full}, 8'h00);
      chk("midrst_en_tens", {7'd0, en_tens}, 8'h00);
      chk("midrst_hs", {hs_tens, hs_ones}, 8'h00);
      chk("midrst_score_lz0", {tens0, ones0}, 8'h00);
      chk("midrst_en_tens_lz0", {7'd0, en_tens0}, 8'h01);
      @(negedge clk);
      chk("post_rst_score", {tens, ones}, 8'h00);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 SHALL have parameter BLANK_LZ, default 1, meaning tens-digit leading-zero blanking is active when 1.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port inc, input, 1 bit: apple-eaten event; a level that may be held for several cycles.
REQ-005 SHALL have port clear, input, 1 bit: game restart; zeroes the current score.
REQ-006 SHALL have port ones, output, 4 bits: BCD units digit of the current score, for the units display decoder.
REQ-007 SHALL have port tens, output, 4 bits: BCD tens digit of the current score.
REQ-008 SHALL have port en_ones, output, 1 bit: enable for the units decoder.
REQ-009 SHALL have port en_tens, output, 1 bit: enable for the tens decoder.
REQ-010 SHALL have port full, output, 1 bit: score is saturated at 99.
REQ-011 SHALL have port hs_ones, output, 4 bits: BCD units digit of the high score.
REQ-012 SHALL have port hs_tens, output, 4 bits: BCD tens digit of the high score.

Function
REQ-013 SHALL register inc every cycle into inc_q, giving a step condition of inc high with inc_q low (rising edge).
REQ-014 SHALL have a two-state FSM: COUNT and SAT.
REQ-015 In COUNT, a step with ones<9 SHALL increment ones by 1 on the next edge.
REQ-016 In COUNT, a step with ones==9 and tens<9 SHALL set ones to 0 and increment tens by 1.
REQ-017 In COUNT, a step with ones==9 and tens==9 SHALL hold the value at 99 and move the FSM to SAT.
REQ-018 The FSM SHALL enter SAT on the edge where the score first becomes 99, whether by REQ-015 (from 98) or by a step at 99.
REQ-019 In SAT, steps SHALL be ignored, the score SHALL hold at 99, and full SHALL be 1.
REQ-020 full SHALL be 1 exactly when the FSM is in SAT.
REQ-021 clear SHALL set ones and tens to 0 and put the FSM in COUNT on the next edge, from either state.
REQ-022 When clear and a step occur in the same cycle, clear SHALL win, and inc_q SHALL still update.
REQ-023 A held inc SHALL produce exactly one increment; a new increment requires inc low for at least one cycle.
REQ-024 ones and tens SHALL never hold values 10-15.
REQ-025 en_ones SHALL be constantly 1.
REQ-026 With BLANK_LZ=1, en_tens SHALL be 0 when tens==0 and 1 otherwise; with BLANK_LZ=0, en_tens SHALL be constantly 1.
REQ-027 All outputs SHALL be registered or derived combinationally only from registers, with no path from inputs to outputs.
REQ-028 The score outputs SHALL reflect a step one cycle after the cycle in which inc rises.

Reset
REQ-029 On rst high at a clock edge: ones=0, tens=0, FSM=COUNT, full=0, inc_q=0, hs_ones=0, hs_tens=0.
REQ-030 rst SHALL take priority over clear and inc, including when asserted mid-count or while in SAT.
REQ-031 After reset, en_tens SHALL be 0 when BLANK_LZ=1.

Configuration
REQ-032 The macro SCORE_HIGH_SCORE_EN SHALL, when defined, include a high-score register pair.
REQ-033 With the macro defined, whenever the registered current score (tens*10+ones) exceeds the high score, the high score SHALL load the current score on the next edge.
REQ-034 With the macro defined, the high score SHALL be unaffected by clear and SHALL be zeroed only by rst.
REQ-035 With the macro not defined, hs_ones and hs_tens SHALL be constant 0 and no high-score storage SHALL be synthesized.

Verification
REQ-036 Bench SHALL cover: rst; then 12 single-cycle inc pulses separated by low cycles -> tens=1, ones=2, en_tens=1, full=0.
REQ-037 Bench SHALL cover: inc held high for 20 cycles after reset -> score=01 exactly, en_tens=0 (BLANK_LZ=1).
REQ-038 Bench SHALL cover: 99 pulses -> 99 with full=1 on that edge; 5 more pulses -> still 99, full=1; then clear -> 00, full=0.
REQ-039 Bench SHALL cover: score 09, then inc rising in the same cycle as clear -> 00 next cycle; next pulse -> 01.
REQ-040 Bench SHALL cover (macro defined): reach 37, clear, reach 15 -> hs=37; reach 38 -> hs=38 one cycle after the score reaches 38; rst -> hs=00.
REQ-041 Bench SHALL cover: rst asserted mid-count at 56 in the same cycle as inc rising -> all outputs 0 next cycle; with BLANK_LZ=0, en_tens=1 at score 00.
